u_rf_mp: RTL
============

Name: u_rf_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read regfile in the core pipeline.
- Generalised in data width, register count, and number of read and write ports.
- Keeps same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so multi-cycle units (load, mul/div) can mark a destination pending at issue and clear it at write-back.
- Sits between decode/issue (reads, scoreboard set) and the write-back stage(s).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; need not be a power of two.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0, is never written, and is never busy.
- BYPASS, 1, when 1, same-cycle writes are forwarded to reads.
- AW, $clog2(NREG), address width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rs_a  in  NRD*AW  read addresses; port i is bits [i*AW +: AW].
- rs_o  out  NRD*XLEN  read data for port i.
- rs_busy_o  out  NRD  busy status of the register read on port i.
- rd_e  in  NWR  write enable per write port.
- rd_a  in  NWR*AW  write address per write port.
- rd_i  in  NWR*XLEN  write data per write port.
- sb_set_e  in  1  mark register sb_set_a pending.
- sb_set_a  in  AW  register to mark pending.
- busy_cnt_o  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (async assert): all registers = 0, all busy bits = 0, busy_cnt_o = 0. Outputs are combinational from that state, so rs_o = 0 and rs_busy_o = 0 while rst is high. Deassertion takes effect at the next clk edge; no other sync logic.
- Valid write: rd_e[p] & (rd_a[p] < NREG) & ~(ZERO_REG & rd_a[p]==0). Invalid writes are silently dropped.
- Write: at posedge, rf[rd_a[p]] <= rd_i[p] for every valid write. Multiple valid writes to the same address in one cycle: highest port index wins.
- Read (combinational, zero latency):
  - Address >= NREG → rs_o = 0, rs_busy_o = 0.
  - ZERO_REG & addr==0 → rs_o = 0 always. Forwarding a write to x0 is forbidden.
  - BYPASS=1 and any valid write matches the address → data from the highest-index matching port.
  - Otherwise → stored value.
  - BYPASS=0 → always the stored value (old data in the write cycle).
- Scoreboard set: sb_set_e with a valid address (same rules as a valid write) sets busy[sb_set_a] at posedge.
- Scoreboard clear: any valid write clears busy[rd_a[p]] at posedge.
- Same cycle, same address, set and clear: set wins (new producer issued as the old one retires). Busy = 1 next cycle, data = written value.
- rs_busy_o[i] = busy[addr] & ~(BYPASS & valid write hitting addr this cycle). A same-cycle sb_set does not affect rs_busy_o until the next cycle.
- busy_cnt_o: registered popcount, updated each posedge alongside busy.
  - Next value = current + (set of a non-busy reg) − (number of distinct busy regs cleared and not re-set).
  - Must always equal the popcount of busy; range 0..NREG (NREG-ZERO_REG max).
- Write-back to a non-busy register is legal: data is written, busy stays 0.

Decomposition:
- Shared package u_rf_pkg holds:
  - default XLEN/NREG constants;
  - typedef rf_addr_t (logic [AW-1:0]) and rf_data_t;
  - function rf_wr_valid(addr, en) used by both write and scoreboard logic.
- One sub-module, u_rf_sb: busy vector, set/clear priority, busy_cnt_o.
- Storage, write-port priority and read/bypass muxes stay in u_rf_mp.

Test Plan:
- Reset: assert rst mid-operation after writing x5=0x1234 and setting busy x5 → immediately rs_o for x5 = 0, rs_busy_o = 0, busy_cnt_o = 0, with no clock needed.
- Zero register: NWR=2, write x0=0xDEAD on port 0 while reading x0 → rs_o = 0 that cycle and after; busy never set by sb_set_a=0.
- Bypass and priority: NWR=2, port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle → read of x7 returns 0x22 that cycle and after. Repeat with BYPASS=0 → old value that cycle, 0x22 next.
- Scoreboard life-cycle: sb_set x3 at cycle 0 → rs_busy_o(x3) = 1 from cycle 1 and busy_cnt_o = 1. Write x3=0x55 at cycle 4 → that cycle rs_busy_o = 0 with rs_o = 0x55; from cycle 5 busy = 0, busy_cnt_o = 0.
- Set/clear collision: x9 busy, write x9=0xAA and sb_set x9 in the same cycle → next cycle rs_o = 0xAA, rs_busy_o = 1, busy_cnt_o unchanged at 1.
- Out-of-range: NREG=24, write addr 30 and sb_set 30 → no state change, busy_cnt_o unchanged; read addr 30 returns 0 and not busy.

Source files
------------

// File: rtl/u_rf_pkg.sv
// u_rf_pkg: shared constants, types and write-validity rule for the multi-port register file
package u_rf_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int AW_D = $clog2(NREG_D);
  typedef logic [AW_D-1:0] rf_addr_t;
  typedef logic [XLEN_D-1:0] rf_data_t;
  // A write (or scoreboard set) counts only when enabled, in range, and not aimed at a hardwired x0.
  function automatic logic rf_wr_valid(input logic [31:0] addr, input logic en, input int nreg, input logic zero_reg);
    return en && (addr < 32'(nreg)) && !(zero_reg && addr == 32'd0);
  endfunction
endpackage

// File: rtl/u_rf_sb.sv
// u_rf_sb: per-register busy scoreboard with set-over-clear priority and a running busy count
// Ports: clk, rst (async, active-high); wr_v per-port validated write strobes; rd_a write addresses;
//        sb_set_e/sb_set_a pending mark; busy vector; busy_cnt popcount of busy.
module u_rf_sb
  import u_rf_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NWR = 1,
  parameter int AW = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NWR-1:0]    wr_v,
  input  logic [NWR*AW-1:0] rd_a,
  input  logic            sb_set_e,
  input  logic [AW-1:0]   sb_set_a,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     busy_cnt
);
  logic [NREG-1:0] set_v, clr_v;
  logic [AW:0] dec;
  logic inc;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      set_v[r] = rf_wr_valid(32'(sb_set_a), sb_set_e, NREG, ZERO_REG != 0) && sb_set_a == AW'(r);
      for (int p = 0; p < NWR; p++) clr_v[r] = clr_v[r] | (wr_v[p] && rd_a[p*AW +: AW] == AW'(r));
      // a register retires only if it was busy and is not re-issued in the same cycle
      dec = dec + (AW+1)'(busy[r] & clr_v[r] & ~set_v[r]);
    end
    inc = |(set_v & ~busy);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= (busy & ~clr_v) | set_v;
      busy_cnt <= busy_cnt + (AW+1)'(inc) - dec;
    end
endmodule

// File: rtl/u_rf_mp.sv
// u_rf_mp: parametrised multi-port register file with write-to-read bypass and busy scoreboard
// Ports: clk, rst (async, active-high); rs_a/rs_o/rs_busy_o read ports; rd_e/rd_a/rd_i write ports;
//        sb_set_e/sb_set_a mark a destination pending; busy_cnt_o number of busy registers.
module u_rf_mp
  import u_rf_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   rs_a,
  output logic [NRD*XLEN-1:0] rs_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic [NWR-1:0]      rd_e,
  input  logic [NWR*AW-1:0]   rd_a,
  input  logic [NWR*XLEN-1:0] rd_i,
  input  logic              sb_set_e,
  input  logic [AW-1:0]     sb_set_a,
  output logic [AW:0]       busy_cnt_o
);
  logic [XLEN-1:0] rf [NREG];
  logic [NWR-1:0] wr_v;
  logic [NREG-1:0] busy;
  always_comb begin
    wr_v = '0;
    for (int p = 0; p < NWR; p++) wr_v[p] = rf_wr_valid(32'(rd_a[p*AW +: AW]), rd_e[p], NREG, ZERO_REG != 0);
  end
  // later ports overwrite earlier ones, so the highest index wins on an address clash
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) if (wr_v[p]) rf[rd_a[p*AW +: AW]] <= rd_i[p*XLEN +: XLEN];
    end
  // the validity rule doubles as the readable-address test: out of range and x0 read as 0, never busy
  always_comb begin
    rs_o = '0;
    rs_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!rst && rf_wr_valid(32'(rs_a[i*AW +: AW]), 1'b1, NREG, ZERO_REG != 0)) begin
        rs_o[i*XLEN +: XLEN] = rf[rs_a[i*AW +: AW]];
        rs_busy_o[i] = busy[rs_a[i*AW +: AW]];
        for (int p = 0; p < NWR; p++)
          if (BYPASS != 0 && wr_v[p] && rd_a[p*AW +: AW] == rs_a[i*AW +: AW]) begin
            rs_o[i*XLEN +: XLEN] = rd_i[p*XLEN +: XLEN];
            rs_busy_o[i] = 1'b0;
          end
      end
    end
  end
  u_rf_sb #(.NREG(NREG), .NWR(NWR), .AW(AW), .ZERO_REG(ZERO_REG)) sb (
    .clk(clk),
    .rst(rst),
    .wr_v(wr_v),
    .rd_a(rd_a),
    .sb_set_e(sb_set_e),
    .sb_set_a(sb_set_a),
    .busy(busy),
    .busy_cnt(busy_cnt_o)
  );
endmodule
